// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared constants, types and index helpers for the WBUF read
// scheduler. A linear block index maps to bank = idx mod N_BANK and
// addr = idx div N_BANK. Indices at or beyond N_BANK*DEPTH are out of range.
package wbuf_pkg;

    localparam int N_BANK = 6;
    localparam int DEPTH  = 11;
    localparam int N_LANE = 4;
    localparam int IDX_W  = 7;
    localparam int CNT_W  = 7;
    localparam int N_BLK  = N_BANK * DEPTH;

    typedef logic [$clog2(N_BANK)-1:0] bank_t;
    typedef logic [$clog2(DEPTH)-1:0]  addr_t;
    // Running index is wide enough that base + count*stride never wraps.
    typedef logic [IDX_W+CNT_W-1:0]    idx_t;
    typedef logic [N_LANE-1:0]         lane_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    function automatic bank_t idx2bank(input idx_t idx);
        return bank_t'(idx % idx_t'(N_BANK));
    endfunction

    function automatic addr_t idx2addr(input idx_t idx);
        return addr_t'(idx / idx_t'(N_BANK));
    endfunction

    function automatic logic idx_in_range(input idx_t idx);
        return idx < idx_t'(N_BLK);
    endfunction

endpackage

// File: rtl/wbuf_rd_sched_if.sv
// wbuf_rd_sched_if: command handshake and WBUF read-select bus of the
// scheduler.
//   slave  : the scheduler (takes cmd_* and hold, drives selects/status)
//   master : the command source / WBUF side
// perf_reads / perf_splits exist only when WBUF_RD_SCHED_PERF_EN is defined.
interface wbuf_rd_sched_if;
    import wbuf_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [IDX_W-1:0]         cmd_base;
    logic [IDX_W-1:0]         cmd_stride;
    logic [CNT_W-1:0]         cmd_count;
    logic                     hold;
    bank_t [N_LANE-1:0]       bank_sel;
    addr_t [N_LANE-1:0]       addr_sel;
    lane_mask_t               en_sel;
    lane_mask_t               port_sel;
    lane_mask_t               rd_valid;
    logic                     rd_last;
    logic                     busy;
    logic                     done;
    logic                     err;
`ifdef WBUF_RD_SCHED_PERF_EN
    logic [31:0]              perf_reads;
    logic [31:0]              perf_splits;
`endif

    modport slave (
        input  cmd_valid, cmd_base, cmd_stride, cmd_count, hold,
        output cmd_ready, bank_sel, addr_sel, en_sel, port_sel,
               rd_valid, rd_last, busy, done, err
`ifdef WBUF_RD_SCHED_PERF_EN
        , output perf_reads, perf_splits
`endif
    );

    modport master (
        output cmd_valid, cmd_base, cmd_stride, cmd_count, hold,
        input  cmd_ready, bank_sel, addr_sel, en_sel, port_sel,
               rd_valid, rd_last, busy, done, err
`ifdef WBUF_RD_SCHED_PERF_EN
        , input perf_reads, perf_splits
`endif
    );

endinterface

// File: rtl/wbuf_lane_alloc.sv
// wbuf_lane_alloc: combinational lane/port allocator for one issue cycle.
//   cand_idx   : up to N_LANE candidate indices in program order
//   cand_vld   : prefix mask of candidates that exist (limited by remaining count)
//   lane_*     : accepted reads packed into lanes 0..n-1, unused lanes zero
//   n_consumed : candidates retired this cycle (issued or out of range)
//   oor        : at least one out-of-range candidate was retired
// Each bank has two ports: first use gets Port A, second Port B. The first
// in-range candidate that would need a third port ends the group.
module wbuf_lane_alloc
    import wbuf_pkg::*;
(
    input  idx_t  [N_LANE-1:0] cand_idx,
    input  lane_mask_t         cand_vld,
    output bank_t [N_LANE-1:0] lane_bank,
    output addr_t [N_LANE-1:0] lane_addr,
    output lane_mask_t         lane_en,
    output lane_mask_t         lane_port,
    output logic [2:0]         n_consumed,
    output logic               oor
);

    logic [1:0] use_cnt [N_BANK];
    logic [2:0] n_lane;
    logic       stop;
    bank_t      b;

    always_comb begin
        lane_bank  = '0;
        lane_addr  = '0;
        lane_en    = '0;
        lane_port  = '0;
        n_consumed = 3'd0;
        oor        = 1'b0;
        n_lane     = 3'd0;
        stop       = 1'b0;
        b          = '0;
        for (int i = 0; i < N_BANK; i++) begin
            use_cnt[i] = 2'd0;
        end
        for (int c = 0; c < N_LANE; c++) begin
            if (cand_vld[c] && !stop) begin
                if (!idx_in_range(cand_idx[c])) begin
                    // Retired without a lane; it never touches a bank.
                    n_consumed = n_consumed + 3'd1;
                    oor        = 1'b1;
                end else begin
                    b = idx2bank(cand_idx[c]);
                    if (use_cnt[b] == 2'd2) begin
                        stop = 1'b1;
                    end else begin
                        lane_bank[n_lane[1:0]] = b;
                        lane_addr[n_lane[1:0]] = idx2addr(cand_idx[c]);
                        lane_port[n_lane[1:0]] = use_cnt[b][0];
                        lane_en[n_lane[1:0]]   = 1'b1;
                        use_cnt[b]             = use_cnt[b] + 2'd1;
                        n_lane                 = n_lane + 3'd1;
                        n_consumed             = n_consumed + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wbuf_rd_sched.sv
// wbuf_rd_sched: turns a (base, stride, count) block-sequence command into
// per-cycle WBUF read selects for four lanes, splitting groups on port
// conflicts, and produces a lane-valid mask delayed RD_LAT cycles to line up
// with WBUF dout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wbuf_rd_sched_if.slave (command, hold, selects, status)
// Optional: define WBUF_RD_SCHED_PERF_EN to add saturating perf_reads and
// perf_splits counters on the interface.
module wbuf_rd_sched
    import wbuf_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    wbuf_rd_sched_if.slave     bus
);

    state_t             state_reg, state_next;
    idx_t               cur_reg, cur_next;
    idx_t               stride_reg, stride_next;
    logic [CNT_W-1:0]   rem_reg, rem_next;
    logic               err_reg, err_next;

    bank_t [N_LANE-1:0] bank_sel_reg, bank_sel_next;
    addr_t [N_LANE-1:0] addr_sel_reg, addr_sel_next;
    lane_mask_t         en_sel_reg, en_sel_next;
    lane_mask_t         port_sel_reg, port_sel_next;
    logic               last_reg, last_next;

    lane_mask_t [RD_LAT-1:0] vld_pipe_reg;
    logic [RD_LAT-1:0]       last_pipe_reg;

    idx_t  [N_LANE-1:0] cand_idx;
    lane_mask_t         cand_vld;
    bank_t [N_LANE-1:0] a_bank;
    addr_t [N_LANE-1:0] a_addr;
    lane_mask_t         a_en;
    lane_mask_t         a_port;
    logic [2:0]         a_cons;
    logic               a_oor;
    logic               issue_fire;
    logic               pipe_empty;

    assign issue_fire = (state_reg == ISSUE) && !bus.hold;
    assign pipe_empty = (en_sel_reg == '0) && (vld_pipe_reg == '0);

    for (genvar gi = 0; gi < N_LANE; gi++) begin : g_cand
        assign cand_idx[gi] = cur_reg + idx_t'(gi) * stride_reg;
        assign cand_vld[gi] = issue_fire && (rem_reg > CNT_W'(gi));
    end

    wbuf_lane_alloc u_alloc (
        .cand_idx   (cand_idx),
        .cand_vld   (cand_vld),
        .lane_bank  (a_bank),
        .lane_addr  (a_addr),
        .lane_en    (a_en),
        .lane_port  (a_port),
        .n_consumed (a_cons),
        .oor        (a_oor)
    );

    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        stride_next   = stride_reg;
        rem_next      = rem_reg;
        err_next      = err_reg;
        bank_sel_next = '0;
        addr_sel_next = '0;
        en_sel_next   = '0;
        port_sel_next = '0;
        last_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cur_next    = idx_t'(bus.cmd_base);
                    stride_next = idx_t'(bus.cmd_stride);
                    rem_next    = bus.cmd_count;
                    err_next    = 1'b0;
                    state_next  = (bus.cmd_count == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.hold) begin
                    cur_next      = cur_reg + idx_t'(a_cons) * stride_reg;
                    rem_next      = rem_reg - CNT_W'(a_cons);
                    bank_sel_next = a_bank;
                    addr_sel_next = a_addr;
                    en_sel_next   = a_en;
                    port_sel_next = a_port;
                    if (a_oor) begin
                        err_next = 1'b1;
                    end
                    // Indices only grow, so once the next index is out of
                    // range no later beat can carry an in-range block.
                    last_next = (a_en != '0) &&
                                ((rem_next == '0) || !idx_in_range(cur_next));
                    if (rem_next == '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            stride_reg    <= '0;
            rem_reg       <= '0;
            err_reg       <= 1'b0;
            bank_sel_reg  <= '0;
            addr_sel_reg  <= '0;
            en_sel_reg    <= '0;
            port_sel_reg  <= '0;
            last_reg      <= 1'b0;
            vld_pipe_reg  <= '0;
            last_pipe_reg <= '0;
        end else begin
            state_reg        <= state_next;
            cur_reg          <= cur_next;
            stride_reg       <= stride_next;
            rem_reg          <= rem_next;
            err_reg          <= err_next;
            bank_sel_reg     <= bank_sel_next;
            addr_sel_reg     <= addr_sel_next;
            en_sel_reg       <= en_sel_next;
            port_sel_reg     <= port_sel_next;
            last_reg         <= last_next;
            vld_pipe_reg[0]  <= en_sel_reg;
            last_pipe_reg[0] <= last_reg;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
                last_pipe_reg[i] <= last_pipe_reg[i-1];
            end
        end
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DRAIN) && pipe_empty;
    assign bus.err       = err_reg;
    assign bus.bank_sel  = bank_sel_reg;
    assign bus.addr_sel  = addr_sel_reg;
    assign bus.en_sel    = en_sel_reg;
    assign bus.port_sel  = port_sel_reg;
    assign bus.rd_valid  = vld_pipe_reg[RD_LAT-1];
    assign bus.rd_last   = last_pipe_reg[RD_LAT-1];

`ifdef WBUF_RD_SCHED_PERF_EN
    logic [31:0] perf_reads_reg;
    logic [31:0] perf_splits_reg;
    logic [32:0] reads_sum;
    logic        split_evt;

    assign reads_sum = {1'b0, perf_reads_reg} + 33'($countones(a_en));
    // Candidates form a prefix mask, so a valid one left unconsumed can only
    // mean the group was cut by a port conflict.
    assign split_evt = issue_fire && (a_cons != 3'd4) && cand_vld[a_cons[1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_reads_reg  <= '0;
            perf_splits_reg <= '0;
        end else begin
            if (issue_fire) begin
                perf_reads_reg <= reads_sum[32] ? '1 : reads_sum[31:0];
            end
            if (split_evt && (perf_splits_reg != '1)) begin
                perf_splits_reg <= perf_splits_reg + 32'd1;
            end
        end
    end

    assign bus.perf_reads  = perf_reads_reg;
    assign bus.perf_splits = perf_splits_reg;
`endif

endmodule

// File: tb/tb_wbuf_rd_sched.sv
// Testbench for wbuf_rd_sched: directed and random commands checked every
// cycle against a behavioural model built from the index/port rules.
module tb_wbuf_rd_sched;

    localparam int RD_LAT = 2;
    localparam int NB     = 6;
    localparam int NBLK   = 66;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wbuf_rd_sched_if bus();

    wbuf_rd_sched #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  port;
        logic [11:0] bank;
        logic [15:0] addr;
        logic        last;
        logic        oor;
    } beat_t;

    beat_t beats[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    // model state: 0 idle, 1 issuing, 2 draining
    int mode;
    int dedge;
    int last_nz;
    logic [3:0]  exp_en, exp_port;
    logic [11:0] exp_bank;
    logic [15:0] exp_addr;
    logic        exp_last, exp_err, exp_done;
    logic [3:0]  en_hist [16];
    logic        last_hist [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
        end
    endtask

    // Expand a command into the list of issue beats (one per non-held cycle).
    task automatic build_beats(input int base, input int stride, input int count);
        int pos, nl, idx, bk;
        int used [NB];
        beat_t b;
        beats.delete();
        pos = 0;
        while (pos < count) begin
            b = '0;
            nl = 0;
            foreach (used[i]) used[i] = 0;
            for (int j = 0; j < 4 && pos < count; j++) begin
                idx = base + pos * stride;
                if (idx >= NBLK) begin
                    b.oor = 1'b1;
                    pos++;
                end else begin
                    bk = idx % NB;
                    if (used[bk] == 2) break;
                    b.en[nl]          = 1'b1;
                    b.port[nl]        = (used[bk] == 1);
                    b.bank[nl*3 +: 3] = 3'(bk);
                    b.addr[nl*4 +: 4] = 4'(idx / NB);
                    used[bk]++;
                    nl++;
                    pos++;
                end
            end
            beats.push_back(b);
        end
        for (int i = beats.size() - 1; i >= 0; i--) begin
            if (beats[i].en != 4'd0) begin
                beats[i].last = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_reset();
        mode     = 0;
        dedge    = 0;
        last_nz  = -100;
        exp_en   = '0; exp_port = '0; exp_bank = '0; exp_addr = '0;
        exp_last = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            en_hist[i]   = '0;
            last_hist[i] = 1'b0;
        end
        beats.delete();
    endtask

    // Advance the model across edge k = edge_cnt with the inputs of this cycle.
    task automatic model_edge(input logic cv, input int base, input int stride,
                              input int count, input logic h);
        int k;
        beat_t b;
        k = edge_cnt;
        exp_en = '0; exp_port = '0; exp_bank = '0; exp_addr = '0; exp_last = 1'b0;
        case (mode)
            0: if (cv) begin
                build_beats(base, stride, count);
                exp_err = 1'b0;
                last_nz = -100;
                if (beats.size() == 0) begin
                    mode  = 2;
                    dedge = k;
                end else begin
                    mode = 1;
                end
            end
            1: if (!h) begin
                b = beats.pop_front();
                exp_en = b.en; exp_port = b.port; exp_bank = b.bank;
                exp_addr = b.addr; exp_last = b.last;
                if (b.oor) exp_err = 1'b1;
                if (b.en != 4'd0) last_nz = k;
                if (beats.size() == 0) begin
                    mode  = 2;
                    dedge = (k > last_nz + RD_LAT + 1) ? k : last_nz + RD_LAT + 1;
                end
            end
            default: if (k - 1 >= dedge) mode = 0;
        endcase
        en_hist[k % 16]   = exp_en;
        last_hist[k % 16] = exp_last;
        exp_done = (mode == 2) && (k >= dedge);
    endtask

    task automatic compare();
        int hk;
        hk = (edge_cnt + 16 - RD_LAT) % 16;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(mode == 0));
        chk("busy",      32'(bus.busy),      32'(mode != 0));
        chk("en_sel",    32'(bus.en_sel),    32'(exp_en));
        chk("bank_sel",  32'(bus.bank_sel),  32'(exp_bank));
        chk("addr_sel",  32'(bus.addr_sel),  32'(exp_addr));
        chk("port_sel",  32'(bus.port_sel),  32'(exp_port));
        chk("rd_valid",  32'(bus.rd_valid),  32'(en_hist[hk]));
        chk("rd_last",   32'(bus.rd_last),   32'(last_hist[hk]));
        chk("done",      32'(bus.done),      32'(exp_done));
        chk("err",       32'(bus.err),       32'(exp_err));
    endtask

    task automatic step(input logic cv, input int base, input int stride,
                        input int count, input logic h);
        @(negedge clk);
        bus.cmd_valid  = cv;
        bus.cmd_base   = 7'(base);
        bus.cmd_stride = 7'(stride);
        bus.cmd_count  = 7'(count);
        bus.hold       = h;
        model_edge(cv, base, stride, count, h);
        @(posedge clk);
        #1;
        compare();
        edge_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.hold      = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        #1;
        compare();
        repeat (2) begin
            @(posedge clk);
            #1;
            compare();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // rnd_hold: random hold; otherwise hold during [hold_after, hold_after+hold_len).
    // rst_after >= 0 asserts reset at that cycle of the command.
    task automatic run_cmd(input int base, input int stride, input int count,
                           input int hold_after, input int hold_len,
                           input bit rnd_hold, input int rst_after);
        int cyc;
        logic h;
        step(1'b1, base, stride, count, 1'b0);
        cyc = 0;
        while (mode != 0 && cyc < 600) begin
            if (cyc == rst_after) begin
                do_reset();
            end else begin
                if (rnd_hold) h = ($urandom_range(0, 3) == 0);
                else          h = (cyc >= hold_after) && (cyc < hold_after + hold_len);
                step(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), h);
            end
            cyc++;
        end
        if (mode != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: command (%0d,%0d,%0d) not finished after %0d cycles", base, stride, count, cyc);
        end
    endtask

    initial begin
        int base, stride, count, rst_at;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_stride = '0;
        bus.cmd_count  = '0;
        bus.hold       = 1'b0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            compare();
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the model against hand-derived beats.
        build_beats(0, 1, 8);
        chk("pin_a_nbeats", 32'(beats.size()), 32'd2);
        chk("pin_a_b0_bank", 32'(beats[0].bank), 32'h688);
        chk("pin_a_b0_en",   32'(beats[0].en),   32'hF);
        chk("pin_a_b1_bank", 32'(beats[1].bank), 32'h22C);
        chk("pin_a_b1_addr", 32'(beats[1].addr), 32'h1100);
        chk("pin_a_b1_last", 32'(beats[1].last), 32'd1);
        build_beats(0, 6, 4);
        chk("pin_b_b0_en",   32'(beats[0].en),   32'h3);
        chk("pin_b_b0_port", 32'(beats[0].port), 32'h2);
        chk("pin_b_b0_addr", 32'(beats[0].addr), 32'h0010);
        chk("pin_b_b1_addr", 32'(beats[1].addr), 32'h0032);
        build_beats(64, 1, 4);
        chk("pin_c_nbeats", 32'(beats.size()), 32'd1);
        chk("pin_c_bank",   32'(beats[0].bank), 32'h02C);
        chk("pin_c_addr",   32'(beats[0].addr), 32'h00AA);
        chk("pin_c_oor",    32'(beats[0].oor),  32'd1);
        beats.delete();

        run_cmd(0, 1, 8, 0, 0, 1'b0, -1);
        run_cmd(0, 6, 4, 0, 0, 1'b0, -1);
        run_cmd(64, 1, 4, 0, 0, 1'b0, -1);
        run_cmd(5, 3, 0, 0, 0, 1'b0, -1);
        run_cmd(0, 1, 8, 1, 3, 1'b0, -1);
        run_cmd(0, 0, 5, 0, 0, 1'b0, -1);
        run_cmd(60, 3, 5, 0, 0, 1'b0, -1);
        run_cmd(70, 0, 9, 0, 0, 1'b0, -1);
        run_cmd(0, 1, 40, 0, 0, 1'b0, 3);
        run_cmd(3, 7, 10, 0, 0, 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            base   = int'($urandom_range(0, 75));
            stride = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) * 6
                                                 : int'($urandom_range(0, 13));
            count  = int'($urandom_range(0, 20));
            rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 5)) : -1;
            run_cmd(base, stride, count, 0, 0, 1'b1, rst_at);
            repeat ($urandom_range(0, 2)) step(1'b0, 0, 0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
